// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags: parametrised single-clock FIFO with occupancy count,
// almost-full/almost-empty thresholds and sticky overflow/underflow flags.
// Optional macro FIFO_FWFT_EN selects first-word-fall-through reads;
// without it reads are registered with one cycle of latency.
module sync_fifo_flags #(
  parameter int DEPTH      = 8,
  parameter int DATA_WIDTH = 8,
  parameter int AF_THRESH  = 6,
  parameter int AE_THRESH  = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wren,
  input  logic [DATA_WIDTH-1:0]    i_data,
  input  logic                     rden,
  output logic [DATA_WIDTH-1:0]    o_data,
  output logic                     o_valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  input  logic                     clr_err,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0]   CNT_AF   = (AW+1)'(AF_THRESH);
  localparam logic [AW:0]   CNT_AE   = (AW+1)'(AE_THRESH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q,  count_d;
  logic          overflow_q, overflow_d;
  logic          underflow_q, underflow_d;
  logic          rd_acc, wr_acc;

  // Status flags decoded from the registered occupancy
  assign count        = count_q;
  assign full         = (count_q == CNT_FULL);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= CNT_AF);
  assign almost_empty = (count_q <= CNT_AE);
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Request acceptance, pointer/count advance and sticky error update
  always_comb begin
    rd_acc      = rden & ~empty;
    // A write into a full FIFO is taken when a read frees the slot this cycle
    wr_acc      = wren & (~full | rd_acc);
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
    // A new error in the same cycle as clr_err keeps the flag set
    overflow_d  = (wren & ~wr_acc) | (overflow_q & ~clr_err);
    underflow_d = (rden & empty) | (underflow_q & ~clr_err);
  end

  // Control state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  // Storage array, not reset; writes suppressed during reset
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem[wr_ptr_q] <= i_data;
  end

`ifdef FIFO_FWFT_EN
  // Head word shown combinationally; rden pops it
  assign o_data  = mem[rd_ptr_q];
  assign o_valid = ~empty;
`else
  logic [DATA_WIDTH-1:0] o_data_q, o_data_d;
  logic                  o_valid_q, o_valid_d;

  assign o_data  = o_data_q;
  assign o_valid = o_valid_q;

  // Capture the popped word; o_valid pulses for one cycle per accepted read
  always_comb begin
    o_data_d  = o_data_q;
    o_valid_d = rd_acc;
    if (rd_acc) o_data_d = mem[rd_ptr_q];
  end

  // Registered read data path
  always_ff @(posedge clk) begin
    if (rst) begin
      o_data_q  <= '0;
      o_valid_q <= 1'b0;
    end else begin
      o_data_q  <= o_data_d;
      o_valid_q <= o_valid_d;
    end
  end
`endif

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Self-checking bench for sync_fifo_flags (DEPTH=8, DATA_WIDTH=8, AF=6, AE=1).
// A queue-based model tracks contents and flags; a negedge process compares
// every output each cycle, and directed sequences pin literal values.
module tb_sync_fifo_flags;

  localparam int DEPTH = 8;
  localparam int DW    = 8;
  localparam int AF    = 6;
  localparam int AE    = 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wren = 1'b0;
  logic [DW-1:0] i_data = '0;
  logic          rden = 1'b0;
  logic          clr_err = 1'b0;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          full, empty, almost_full, almost_empty;
  logic [3:0]    count;
  logic          overflow, underflow;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          check_en = 1'b0;

  // Behavioural model state
  logic [DW-1:0] q[$];
  logic          m_ovf = 1'b0;
  logic          m_unf = 1'b0;
  logic [DW-1:0] m_odata = '0;
  logic          m_ovalid = 1'b0;

  sync_fifo_flags #(
    .DEPTH(DEPTH), .DATA_WIDTH(DW), .AF_THRESH(AF), .AE_THRESH(AE)
  ) dut (
    .clk(clk), .rst(rst), .wren(wren), .i_data(i_data), .rden(rden),
    .o_data(o_data), .o_valid(o_valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .clr_err(clr_err), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs seen at that edge
  task automatic model_edge();
    bit m_empty, m_full, racc, wacc;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0; m_unf = 1'b0; m_odata = '0; m_ovalid = 1'b0;
    end else begin
      m_empty = (q.size() == 0);
      m_full  = (q.size() == DEPTH);
      racc = rden && !m_empty;
      wacc = wren && (!m_full || racc);
      if (racc) m_odata = q[0];
      m_ovalid = racc;
      if (racc) void'(q.pop_front());
      if (wacc) q.push_back(i_data);
      if (wren && !wacc) m_ovf = 1'b1; else if (clr_err) m_ovf = 1'b0;
      if (rden && m_empty) m_unf = 1'b1; else if (clr_err) m_unf = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, update the model on the edge, settle 1 time unit
  task automatic step(input logic r, input logic w, input logic [DW-1:0] d,
                      input logic rd, input logic c);
    rst = r; wren = w; i_data = d; rden = rd; clr_err = c;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  // Every-cycle comparison of DUT outputs against the model
  always @(negedge clk) begin
    if (check_en) begin
      chk("count",        32'(count),        32'(q.size()));
      chk("empty",        32'(empty),        32'(q.size() == 0));
      chk("full",         32'(full),         32'(q.size() == DEPTH));
      chk("almost_full",  32'(almost_full),  32'(q.size() >= AF));
      chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
      chk("overflow",     32'(overflow),     32'(m_ovf));
      chk("underflow",    32'(underflow),    32'(m_unf));
`ifdef FIFO_FWFT_EN
      chk("o_valid",      32'(o_valid),      32'(q.size() != 0));
      if (q.size() != 0) chk("o_data", 32'(o_data), 32'(q[0]));
`else
      chk("o_valid",      32'(o_valid),      32'(m_ovalid));
      chk("o_data",       32'(o_data),       32'(m_odata));
`endif
    end
  end

  initial begin
    int unsigned pw, pr;

    // 1: reset and idle
    step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    check_en = 1'b1;
    step(1'b1, 1'b0, 8'h11, 1'b0, 1'b0);
    step(1'b0, 1'b0, 8'h11, 1'b0, 1'b0);
    chk("t1_empty", 32'(empty), 32'd1);
    chk("t1_ae", 32'(almost_empty), 32'd1);
    chk("t1_count", 32'(count), 32'd0);
    chk("t1_valid", 32'(o_valid), 32'd0);
`ifndef FIFO_FWFT_EN
    chk("t1_odata", 32'(o_data), 32'h00);
`endif

    // 2: single word through
    step(1'b0, 1'b1, 8'h11, 1'b0, 1'b0);
    chk("t2_count1", 32'(count), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t2_count0", 32'(count), 32'd0);
    chk("t2_empty", 32'(empty), 32'd1);
`ifndef FIFO_FWFT_EN
    chk("t2_odata", 32'(o_data), 32'h11);
    chk("t2_valid", 32'(o_valid), 32'd1);
`endif

    // 3: fill, overflow, drain in order, clear error
    for (int i = 1; i <= 8; i++) begin
      step(1'b0, 1'b1, 8'(i), 1'b0, 1'b0);
      if (i == 5) chk("t3_af_at5", 32'(almost_full), 32'd0);
      if (i == 6) chk("t3_af_at6", 32'(almost_full), 32'd1);
      if (i == 7) chk("t3_full_at7", 32'(full), 32'd0);
    end
    chk("t3_full", 32'(full), 32'd1);
    step(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_count", 32'(count), 32'd8);
    for (int i = 1; i <= 8; i++) begin
`ifdef FIFO_FWFT_EN
      chk("t3_head", 32'(o_data), 32'(i));
`endif
      step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
      chk("t3_rdata", 32'(o_data), 32'(i));
`endif
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("t3_clr", 32'(overflow), 32'd0);

    // 4: simultaneous write+read while full
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'hAA, 1'b1, 1'b0);
    chk("t4_count", 32'(count), 32'd8);
    chk("t4_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
    chk("t4_last", 32'(o_data), 32'hAA);
`endif
    chk("t4_empty", 32'(empty), 32'd1);

    // 5: underflow, write+read on empty, wrap, mid-stream reset
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_unf", 32'(underflow), 32'd1);
    step(1'b0, 1'b1, 8'h33, 1'b1, 1'b0);
    chk("t5_count", 32'(count), 32'd1);
    chk("t5_unf_hold", 32'(underflow), 32'd1);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 8'(8'h40 + i), 1'b1, 1'b0);
`ifndef FIFO_FWFT_EN
    chk("t5_wrap", 32'(o_data), 32'h52);
`endif
    step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h78, 1'b0, 1'b0);
    step(1'b1, 1'b1, 8'h79, 1'b1, 1'b0);
    chk("t5_rst_count", 32'(count), 32'd0);
    chk("t5_rst_empty", 32'(empty), 32'd1);
    chk("t5_rst_unf", 32'(underflow), 32'd0);

`ifdef FIFO_FWFT_EN
    // 6: fall-through head without rden
    step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b0);
    chk("t6_valid", 32'(o_valid), 32'd1);
    chk("t6_odata", 32'(o_data), 32'h5A);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("t6_empty", 32'(empty), 32'd1);
    chk("t6_valid0", 32'(o_valid), 32'd0);
`endif

    // Randomised traffic with varying write/read pressure
    pw = 50; pr = 50;
    for (int n = 0; n < 3000; n++) begin
      if (n % 200 == 0) begin
        pw = $urandom_range(10, 90);
        pr = $urandom_range(10, 90);
      end
      step(($urandom_range(0, 299) == 0),
           ($urandom_range(0, 99) < pw),
           8'($urandom),
           ($urandom_range(0, 99) < pr),
           ($urandom_range(0, 15) == 0));
    end

    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
